pdl_ptr_ctl: RTL and testbench
==============================

// Module: pdl_ptr_ctl
// PURPOSE
//  Pointer/index stage directly downstream of the source/dest op decoder. Consumes the decoded
//  PDL source/destination strobes, holds PDL pointer and PDL index, generates the PDL RAM
//  read address, delays destination writes by one cycle into the RAM write port, and
//  bypasses a pending write to a same-address read. Sits between the decoder and the PDL RAM / M-bus mux.
// PARAMETERS
//  PDL_AW  10  PDL address width (1024 words); pointer and index width
//  DW      32  data width of ob, PDL RAM and M-bus
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  reset      in   1       synchronous, active-high reset
//  step       in   1       microinstruction retire strobe; state updates only when high
//  srcpdltop  in   1       M-source = PDL[ptr], no pop
//  srcpdlpop  in   1       M-source = PDL[ptr], then ptr-1
//  srcpdlidx  in   1       M-source = PDL[idx]
//  srcpdlptr  in   1       M-source = pointer value (zero-extended)
//  destpdltop in   1       write ob to PDL[ptr]
//  destpdl_p  in   1       push: ptr+1, write ob to PDL[ptr+1]
//  destpdl_x  in   1       write ob to PDL[idx]
//  destpdlp   in   1       load ptr from ob[PDL_AW-1:0]
//  destpdlx   in   1       load idx from ob[PDL_AW-1:0]
//  ob         in   DW      result bus of the current instruction
//  pdl_rdata  in   DW      PDL RAM read data (combinational from pdl_raddr)
//  pdl_raddr  out  PDL_AW  PDL RAM read address
//  pdl_waddr  out  PDL_AW  PDL RAM write address
//  pdl_wdata  out  DW      PDL RAM write data
//  pdl_we     out  1       PDL RAM write enable
//  mf_pdl     out  DW      value driven onto M-bus for any PDL source
//  pdlptr     out  PDL_AW  current pointer
//  pdlidx     out  PDL_AW  current index
// BEHAVIOUR
//  - Reset (sync, dominates step): pdlptr=0, pdlidx=0, pend_v=0, pdl_we=0, pdl_waddr=0, pdl_wdata=0.
//  - pdl_raddr = srcpdlidx ? pdlidx : pdlptr (combinational, current-instruction values).
//  - mf_pdl: srcpdlptr -> {0,pdlptr}; else bypass-or-RAM data. Bypass when pend_v && pdl_waddr==pdl_raddr:
//    mf_pdl = pdl_wdata, else pdl_rdata. Combinational, zero added latency.
//  - Write pipeline: on step with any of destpdltop/destpdl_p/destpdl_x, register
//    pdl_waddr (idx for _x, ptr_next for _p, pre-step ptr for top), pdl_wdata=ob, pend_v=1.
//    pdl_we = pend_v; RAM writes in the cycle after step. pend_v clears next cycle unless a
//    new write is captured (back-to-back steps give one write per cycle, no loss).
//  - Pointer update on step, priority: destpdlp load > (push/pop arithmetic) > hold.
//    push only: +1; pop only: -1; push and pop together: unchanged, write addr = pre-step ptr
//    (replace top). All arithmetic modulo 2^PDL_AW: 0-1 -> 1023, 1023+1 -> 0, no flag.
//  - destpdlp with destpdl_p same step: load wins, write still targets pre-step ptr+1.
//  - Index: destpdlx loads from ob on step; otherwise holds. Never auto-increments.
//  - Without step no register changes except pend_v/pdl_we retirement.
//  - Reset mid-write: pending write discarded, pdl_we low the next cycle.
//  - Decoder guarantees one-hot within src group and within dest group; combinations across groups legal.
// STRUCTURE
//  - Shared package: PDL_AW/DW defaults, pdl_wsel_t enum {WS_NONE,WS_TOP,WS_PUSH,WS_IDX}.
//  - One sub-module: pdl_wr_pipe (pending write register + address compare/bypass mux).
//  - Pointer/index registers and next-pointer arithmetic stay in the top.
// TESTING
//  - Reset, then step+destpdlp ob=0x3FE; 3x step+destpdl_p ob=A,B,C -> writes at 0x3FF,0x000,0x001, ptr=0x001.
//  - ptr=0, step+srcpdlpop -> raddr=0, ptr=0x3FF; further pop -> 0x3FE.
//  - step+destpdl_p ob=0x1234, next cycle srcpdltop -> mf_pdl=0x1234 via bypass while pdl_we=1.
//  - srcpdlpop+destpdl_p same step ptr=5, ob=7 -> ptr stays 5, write PDL[5]=7.
//  - step+destpdlx ob=0x40, step+destpdl_x ob=9, srcpdlidx -> waddr=0x40, raddr=0x40, mf_pdl=9.
//  - reset asserted the cycle after a destpdltop step -> pdl_we=0, ptr=idx=0 next cycle.

Source files
------------

// File: rtl/pdl_ptr_ctl_pkg.sv
// Shared widths and write-source select for the PDL pointer/index stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pdl_ptr_ctl_pkg;

  localparam int PDL_AW = 10;
  localparam int DW     = 32;

  // Which pre-step address a captured destination write targets.
  typedef enum logic [1:0] {
    WS_NONE,
    WS_TOP,
    WS_PUSH,
    WS_IDX
  } pdl_wsel_t;

endpackage

// File: rtl/pdl_ptr_ctl_if.sv
// Decoder-side strobes, result bus and PDL RAM / M-bus signals of the pointer stage.
// Latency: n/a (wiring only).
// Backpressure: none; the stage consumes one instruction per step strobe.
interface pdl_ptr_ctl_if #(
  parameter int PDL_AW = pdl_ptr_ctl_pkg::PDL_AW,
  parameter int DW     = pdl_ptr_ctl_pkg::DW
);

  logic              step;
  logic              srcpdltop;
  logic              srcpdlpop;
  logic              srcpdlidx;
  logic              srcpdlptr;
  logic              destpdltop;
  logic              destpdl_p;
  logic              destpdl_x;
  logic              destpdlp;
  logic              destpdlx;
  logic [DW-1:0]     ob;
  logic [DW-1:0]     pdl_rdata;
  logic [PDL_AW-1:0] pdl_raddr;
  logic [PDL_AW-1:0] pdl_waddr;
  logic [DW-1:0]     pdl_wdata;
  logic              pdl_we;
  logic [DW-1:0]     mf_pdl;
  logic [PDL_AW-1:0] pdlptr;
  logic [PDL_AW-1:0] pdlidx;

  modport master (
    output step, srcpdltop, srcpdlpop, srcpdlidx, srcpdlptr,
           destpdltop, destpdl_p, destpdl_x, destpdlp, destpdlx, ob, pdl_rdata,
    input  pdl_raddr, pdl_waddr, pdl_wdata, pdl_we, mf_pdl, pdlptr, pdlidx
  );

  modport slave (
    input  step, srcpdltop, srcpdlpop, srcpdlidx, srcpdlptr,
           destpdltop, destpdl_p, destpdl_x, destpdlp, destpdlx, ob, pdl_rdata,
    output pdl_raddr, pdl_waddr, pdl_wdata, pdl_we, mf_pdl, pdlptr, pdlidx
  );

endinterface

// File: rtl/pdl_wr_pipe.sv
// Pending PDL write register with same-address read bypass.
// Latency: write reaches the RAM port one cycle after step; bypass is combinational.
// Backpressure: none; a new capture each step retires the previous write the same cycle.
module pdl_wr_pipe
  import pdl_ptr_ctl_pkg::*;
#(
  parameter int AW = PDL_AW,
  parameter int W  = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  pdl_wsel_t     wsel,
  input  logic [AW-1:0] ptr,
  input  logic [AW-1:0] ptr_arith,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wr_dat,
  input  logic [AW-1:0] raddr,
  input  logic [W-1:0]  rdata,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  wdata,
  output logic [W-1:0]  rd_dat
);

  logic          pend_v;
  logic          cap;
  logic [AW-1:0] cap_addr;

  assign cap = step && (wsel != WS_NONE);

  // Push targets the post-arithmetic pointer; with a simultaneous pop that equals ptr.
  always_comb begin
    cap_addr = ptr;
    case (wsel)
      WS_TOP:  cap_addr = ptr;
      WS_PUSH: cap_addr = ptr_arith;
      WS_IDX:  cap_addr = idx;
      default: cap_addr = ptr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      pend_v <= cap;
      if (cap) begin
        waddr <= cap_addr;
        wdata <= wr_dat;
      end
    end
  end

  assign we     = pend_v;
  assign rd_dat = (pend_v && (waddr == raddr)) ? wdata : rdata;

endmodule

// File: rtl/pdl_ptr_ctl.sv
// PDL pointer/index registers, RAM read address and M-bus source for PDL operands.
// Latency: read path combinational; pointer/index update and RAM write one cycle after step.
// Backpressure: none; every step is absorbed, state holds while step is low.
module pdl_ptr_ctl #(
  parameter int PDL_AW = pdl_ptr_ctl_pkg::PDL_AW,
  parameter int DW     = pdl_ptr_ctl_pkg::DW
) (
  input  logic         clk,
  input  logic         reset,
  pdl_ptr_ctl_if.slave bus
);

  import pdl_ptr_ctl_pkg::*;

  localparam logic [PDL_AW-1:0] PTR_ONE = PDL_AW'(1);

  logic [PDL_AW-1:0] ptr_q;
  logic [PDL_AW-1:0] idx_q;
  logic [PDL_AW-1:0] ptr_arith;
  logic [PDL_AW-1:0] ob_lo;
  pdl_wsel_t         wsel;
  logic [DW-1:0]     byp_dat;

  assign ob_lo = bus.ob[PDL_AW-1:0];

  // Push and pop in the same instruction replace the top: pointer unchanged.
  always_comb begin
    ptr_arith = ptr_q;
    if (bus.destpdl_p && !bus.srcpdlpop) begin
      ptr_arith = ptr_q + PTR_ONE;
    end else if (bus.srcpdlpop && !bus.destpdl_p) begin
      ptr_arith = ptr_q - PTR_ONE;
    end
  end

  always_comb begin
    wsel = WS_NONE;
    if (bus.destpdl_x) begin
      wsel = WS_IDX;
    end else if (bus.destpdl_p) begin
      wsel = WS_PUSH;
    end else if (bus.destpdltop) begin
      wsel = WS_TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      idx_q <= '0;
    end else if (bus.step) begin
      ptr_q <= bus.destpdlp ? ob_lo : ptr_arith;
      if (bus.destpdlx) begin
        idx_q <= ob_lo;
      end
    end
  end

  assign bus.pdl_raddr = bus.srcpdlidx ? idx_q : ptr_q;
  assign bus.pdlptr    = ptr_q;
  assign bus.pdlidx    = idx_q;

  pdl_wr_pipe #(
    .AW (PDL_AW),
    .W  (DW)
  ) u_wr_pipe (
    .clk       (clk),
    .reset     (reset),
    .step      (bus.step),
    .wsel      (wsel),
    .ptr       (ptr_q),
    .ptr_arith (ptr_arith),
    .idx       (idx_q),
    .wr_dat    (bus.ob),
    .raddr     (bus.pdl_raddr),
    .rdata     (bus.pdl_rdata),
    .we        (bus.pdl_we),
    .waddr     (bus.pdl_waddr),
    .wdata     (bus.pdl_wdata),
    .rd_dat    (byp_dat)
  );

  assign bus.mf_pdl = bus.srcpdlptr ? {{(DW-PDL_AW){1'b0}}, ptr_q} : byp_dat;

endmodule

// File: tb/tb_pdl_ptr_ctl.sv
// Bench for pdl_ptr_ctl: directed scenarios then random instructions against a stack/array model.
module tb_pdl_ptr_ctl;
  import pdl_ptr_ctl_pkg::*;

  localparam int AW    = PDL_AW;
  localparam int W     = DW;
  localparam int DEPTH = 1 << AW;

  // src = {top, pop, idx, ptr}; dst = {top, push, wr_idx, ld_ptr, ld_idx}
  localparam logic [3:0] S_NONE = 4'b0000, S_TOP = 4'b1000, S_POP = 4'b0100, S_IDX = 4'b0010, S_PTR = 4'b0001;
  localparam logic [4:0] D_NONE = 5'b00000, D_TOP = 5'b10000, D_PUSH = 5'b01000, D_WX = 5'b00100,
                         D_LDP = 5'b00010, D_LDX = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pdl_ptr_ctl_if #(.PDL_AW(AW), .DW(W)) bus ();

  pdl_ptr_ctl #(.PDL_AW(AW), .DW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment RAM behind the DUT's ports.
  logic [W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) if (bus.pdl_we) ram[bus.pdl_waddr] <= bus.pdl_wdata;
  assign bus.pdl_rdata = ram[bus.pdl_raddr];

  // Architectural model: writes are visible to the very next instruction.
  logic [W-1:0]  mmem [0:DEPTH-1];
  logic [AW-1:0] mptr, midx, exp_waddr;
  logic [W-1:0]  exp_wdata;
  logic          exp_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("pdlptr", 32'(bus.pdlptr), 32'(mptr));
    chk("pdlidx", 32'(bus.pdlidx), 32'(midx));
    chk("pdl_we", 32'(bus.pdl_we), 32'(exp_we));
    chk("pdl_waddr", 32'(bus.pdl_waddr), 32'(exp_waddr));
    chk("pdl_wdata", bus.pdl_wdata, exp_wdata);
  endtask

  task automatic drive(input logic stp, input logic [3:0] src, input logic [4:0] dst, input logic [W-1:0] obv);
    bus.step = stp;
    {bus.srcpdltop, bus.srcpdlpop, bus.srcpdlidx, bus.srcpdlptr} = src;
    {bus.destpdltop, bus.destpdl_p, bus.destpdl_x, bus.destpdlp, bus.destpdlx} = dst;
    bus.ob = obv;
  endtask

  task automatic instr(input logic stp, input logic [3:0] src, input logic [4:0] dst, input logic [W-1:0] obv);
    logic [AW-1:0] p, x, a, wa;
    logic push, pop;
    @(negedge clk);
    drive(stp, src, dst, obv);
    #1;
    p = mptr;
    x = midx;
    a = src[1] ? x : p;
    chk("pdl_raddr", 32'(bus.pdl_raddr), 32'(a));
    if (src[0]) chk("mf_pdl_ptr", bus.mf_pdl, 32'(p));
    else if (|src[3:1]) chk("mf_pdl_data", bus.mf_pdl, mmem[a]);
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    if (stp) begin
      push = dst[3];
      pop  = src[2];
      if (|dst[4:2]) begin
        if (dst[2]) wa = x;
        else if (dst[3]) wa = pop ? p : p + 1;
        else wa = p;
        mmem[wa]  = obv;
        exp_we    = 1'b1;
        exp_waddr = wa;
        exp_wdata = obv;
      end
      if (dst[1]) mptr = obv[AW-1:0];
      else if (push && !pop) mptr = p + 1;
      else if (pop && !push) mptr = p - 1;
      if (dst[0]) midx = obv[AW-1:0];
    end
    chk_state();
  endtask

  initial begin
    logic [3:0] src;
    logic [4:0] dst;
    logic [W-1:0] obv;
    int k;
    drive(1'b0, S_NONE, D_NONE, '0);
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]  = $urandom;
      mmem[i] = ram[i];
    end
    mptr = '0; midx = '0; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_state();
    reset = 1'b0;

    // Pointer load near the top, then three pushes wrap through zero.
    instr(1'b1, S_NONE, D_LDP, 32'h3FE);
    instr(1'b1, S_NONE, D_PUSH, 32'hA);
    chk("push_wrap_waddr0", 32'(bus.pdl_waddr), 32'h3FF);
    instr(1'b1, S_NONE, D_PUSH, 32'hB);
    chk("push_wrap_waddr1", 32'(bus.pdl_waddr), 32'h000);
    instr(1'b1, S_NONE, D_PUSH, 32'hC);
    chk("push_wrap_ptr", 32'(bus.pdlptr), 32'h001);

    // Pop below zero wraps to the top.
    instr(1'b1, S_NONE, D_LDP, 32'h0);
    instr(1'b1, S_POP, D_NONE, 32'h0);
    chk("pop_wrap_ptr", 32'(bus.pdlptr), 32'h3FF);
    instr(1'b1, S_POP, D_NONE, 32'h0);
    chk("pop_again_ptr", 32'(bus.pdlptr), 32'h3FE);

    // Push then immediate read of the top must come from the pending write.
    instr(1'b1, S_NONE, D_PUSH, 32'h1234);
    chk("bypass_we", 32'(bus.pdl_we), 32'h1);
    instr(1'b0, S_TOP, D_NONE, 32'h0);

    // Push and pop together replace the top.
    instr(1'b1, S_NONE, D_LDP, 32'h5);
    instr(1'b1, S_POP, D_PUSH, 32'h7);
    chk("replace_ptr", 32'(bus.pdlptr), 32'h5);
    chk("replace_waddr", 32'(bus.pdl_waddr), 32'h5);
    instr(1'b0, S_TOP, D_NONE, 32'h0);

    // Load ptr and push together: load wins, write goes to old ptr+1.
    instr(1'b1, S_NONE, D_PUSH | D_LDP, 32'h200);
    chk("ldp_push_waddr", 32'(bus.pdl_waddr), 32'h6);

    // Index load, indexed write, indexed read through bypass.
    instr(1'b1, S_NONE, D_LDX, 32'h40);
    instr(1'b1, S_NONE, D_WX, 32'h9);
    chk("idx_waddr", 32'(bus.pdl_waddr), 32'h40);
    instr(1'b0, S_IDX, D_NONE, 32'h0);
    instr(1'b0, S_PTR, D_NONE, 32'h0);

    // Reset the cycle after a write step.
    instr(1'b1, S_NONE, D_TOP, 32'hDEAD);
    @(negedge clk);
    drive(1'b0, S_NONE, D_NONE, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mptr = '0; midx = '0; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    chk_state();
    @(negedge clk);
    reset = 1'b0;

    // Random instruction stream.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 4);
      src = (k == 0) ? S_NONE : 4'(4'b1 << (k - 1));
      k = $urandom_range(0, 3);
      dst = (k == 0) ? D_NONE : 5'(5'b1 << (5 - k));
      k = $urandom_range(0, 5);
      if (k == 1) dst = dst | D_LDP;
      if (k == 2) dst = dst | D_LDX;
      obv = $urandom;
      if ($urandom_range(0, 3) == 0) obv = (obv & 32'hFFFF_FC00) | 32'($urandom_range(0, 3));
      instr($urandom_range(0, 3) != 0, src, dst, obv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
